// File: rtl/serial_sub16_if.sv
// serial_sub16_if
//   Groups the start/done handshake, the operands and the result/flag outputs
//   of the bit-serial subtractor into one bundle.
//   master : the requester. It drives start, a, b and b_in, and observes busy,
//            done, d and the flags.
//   slave  : the subtractor. It observes start and the operands, and drives
//            busy, done, d and the flags.
interface serial_sub16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output start, a, b, b_in,
        input  busy, done, d, b_out, zero, neg, ovf
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, d, b_out, zero, neg, ovf
    );
endinterface

// File: rtl/serial_sub16.sv
// serial_sub16
//   Bit-serial subtractor computing d = a - b - b_in with a single
//   full-subtractor cell. It handles one bit per clock, LSB first, and
//   completes WIDTH cycles after start is accepted.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; it aborts any operation in flight
//   bus   : serial_sub16_if slave modport
//           (start/a/b/b_in in; busy/done/d/b_out/zero/neg/ovf out)
//   WIDTH must be at least 2.
module serial_sub16 #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_sub16_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             br;

    logic             x;
    logic             y;
    logic             diff_bit;
    logic             br_nxt;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] res_full;

    logic [WIDTH-1:0] d_q;
    logic             b_out_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
    logic             done_q;

    // Full-subtractor cell plus FSM next-state decode.
    always_comb begin
        x         = sa[0];
        y         = sb[0];
        diff_bit  = x ^ y ^ br;
        br_nxt    = (~x & y) | (~(x ^ y) & br);
        res_full  = {diff_bit, res[WIDTH-1:1]};
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    last_bit  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand shift registers, borrow, counter and the result registers.
    // The visible outputs load only on the last bit, so partial results
    // never appear on d or the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa      <= '0;
            sb      <= '0;
            res     <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            d_q     <= '0;
            b_out_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                sa  <= bus.a;
                sb  <= bus.b;
                br  <= bus.b_in;
                cnt <= '0;
                res <= '0;
            end else if (state == RUN) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                br  <= br_nxt;
                cnt <= cnt + 1'b1;
                res <= res_full;
                if (last_bit) begin
                    // While the MSB is processed, br is the borrow into the
                    // MSB. That is the value left after bit WIDTH-2. Signed
                    // overflow is that borrow XOR the borrow out.
                    d_q     <= res_full;
                    b_out_q <= br_nxt;
                    zero_q  <= (res_full == '0);
                    neg_q   <= diff_bit;
                    ovf_q   <= br ^ br_nxt;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = done_q;
    assign bus.d     = d_q;
    assign bus.b_out = b_out_q;
    assign bus.zero  = zero_q;
    assign bus.neg   = neg_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_sub16.sv
// tb_serial_sub16
//   Scoreboard bench for serial_sub16. The driver pushes the expected result
//   of each accepted operation into a queue. A monitor pops and compares it
//   whenever done is high.
module tb_serial_sub16;
    typedef struct {
        logic [15:0] d;
        logic        b_out;
        logic        zero;
        logic        neg;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   assertCount;
    int   failCount;
    int   cycle;
    int   lastDone;
    bit   periodCheck;
    exp_t sbQ[$];
    exp_t snap;

    serial_sub16_if #(.WIDTH(16)) bus ();

    serial_sub16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference model, independent of the bit-serial datapath.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        exp_t        e;
        logic [16:0] r;
        int          sr;
        r  = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.d     = r[15:0];
        e.b_out = r[16];
        e.zero  = (r[15:0] == 16'd0);
        e.neg   = r[15];
        e.ovf   = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic z,
                                input logic n, input logic o);
        exp_t e;
        e.d = d; e.b_out = bo; e.zero = z; e.neg = n; e.ovf = o;
        return e;
    endfunction

    task automatic check1(input string name, input logic [15:0] act, input logic [15:0] req);
        assertCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        check1({tag, ".d"},     bus.d,              e.d);
        check1({tag, ".b_out"}, {15'd0, bus.b_out}, {15'd0, e.b_out});
        check1({tag, ".zero"},  {15'd0, bus.zero},  {15'd0, e.zero});
        check1({tag, ".neg"},   {15'd0, bus.neg},   {15'd0, e.neg});
        check1({tag, ".ovf"},   {15'd0, bus.ovf},   {15'd0, e.ovf});
    endtask

    // Monitor: checks each done pulse against the scoreboard, checks the
    // spacing of done pulses under continuous start, and checks that the
    // outputs hold steady between done pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            snap = mk(16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (bus.done) begin
            if (sbQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cycle);
            end else begin
                checkOutput("result", sbQ.pop_front());
            end
            if (periodCheck && lastDone >= 0)
                check1("done_period", 16'(cycle - lastDone), 16'd17);
            lastDone = cycle;
            snap = mk(bus.d, bus.b_out, bus.zero, bus.neg, bus.ovf);
        end else begin
            checkOutput("hold", snap);
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                 input exp_t e);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.b_in  = bin;
        sbQ.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
        bus.b_in  = 1'b1;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((bus.busy || sbQ.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        assertCount++;
        if (bus.busy || sbQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL timeout: got busy=%0b pending=%0d, expected idle with 0 pending",
                     bus.busy, sbQ.size());
            sbQ.delete();
        end
    endtask

    initial begin
        int   n;
        logic [15:0] ra, rb;
        logic        rbin;
        assertCount = 0;
        failCount   = 0;
        cycle       = 0;
        lastDone    = -1;
        periodCheck = 1'b0;
        bus.start = 1'b0;
        bus.a     = 16'd0;
        bus.b     = 16'd0;
        bus.b_in  = 1'b0;
        rst_n     = 1'b0;
        #1;
        check1("reset.busy", {15'd0, bus.busy}, 16'd0);
        check1("reset.done", {15'd0, bus.done}, 16'd0);
        checkOutput("reset", mk(16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 5 - 3: busy must stay high for exactly 16 sampled cycles.
        applyStimulus(16'h0005, 16'h0003, 1'b0, mk(16'h0002, 0, 0, 0, 0));
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check1("busy_cycles", 16'(n), 16'd16);
        waitIdle();

        applyStimulus(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1, 0, 1, 0));
        waitIdle();
        applyStimulus(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 0, 0, 0, 1));
        waitIdle();
        applyStimulus(16'h1234, 16'h1233, 1'b1, mk(16'h0000, 0, 1, 0, 0));
        waitIdle();
        applyStimulus(16'h1234, 16'h1234, 1'b1, mk(16'hFFFF, 1, 0, 1, 0));
        waitIdle();

        // A start raised while busy must be ignored.
        applyStimulus(16'h00FF, 16'h000F, 1'b0, mk(16'h00F0, 0, 0, 0, 0));
        repeat (4) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h0000; bus.b_in = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        waitIdle();

        // Reset asserted mid-run: outputs clear at once, and no done follows.
        applyStimulus(16'h00FF, 16'h000F, 1'b0, mk(16'h00F0, 0, 0, 0, 0));
        repeat (7) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        sbQ.delete();
        #1;
        check1("abort.busy", {15'd0, bus.busy}, 16'd0);
        check1("abort.done", {15'd0, bus.done}, 16'd0);
        checkOutput("abort", mk(16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1, 0, 1, 1));
        waitIdle();

        // Random operands with start held high continuously.
        lastDone    = -1;
        periodCheck = 1'b1;
        bus.start   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            bus.a = ra; bus.b = rb; bus.b_in = rbin;
            sbQ.push_back(model(ra, rb, rbin));
            @(posedge clk); #1;
            bus.a = 16'($urandom); bus.b = 16'($urandom); bus.b_in = 1'($urandom);
            repeat (16) begin @(posedge clk); #1; end
        end
        bus.start = 1'b0;
        waitIdle();
        periodCheck = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/serial_sub16.md
# serial_sub16

Bit-serial 16-bit subtractor computing `d = a - b - b_in` with borrow-out and status flags. It processes one bit per clock, LSB first, through a single full-subtractor cell. It is the inverse-direction companion to the team's ripple-carry adder (`fulladd16`). It sits in area-constrained datapaths where a start/done handshake is acceptable in exchange for one-cell arithmetic.

## Interface
- `WIDTH`, 16, operand/result width in bits; all counts below scale with it.
- `clk` input 1, single clock; all state updates on the rising edge.
- `rst_n` input 1, asynchronous active-low reset.
- `start` input 1, request; sampled only when `busy`=0.
- `a` input WIDTH, minuend; sampled with an accepted `start`.
- `b` input WIDTH, subtrahend; sampled with an accepted `start`.
- `b_in` input 1, borrow-in; sampled with an accepted `start`.
- `busy` output 1, high while an operation is in progress.
- `done` output 1, one-cycle pulse marking that the result registers have just been updated.
- `d` output WIDTH, difference `(a - b - b_in) mod 2^WIDTH`.
- `b_out` output 1, borrow out of the MSB (1 when unsigned `a < b + b_in`).
- `zero` output 1, `d == 0`.
- `neg` output 1, `d[WIDTH-1]`.
- `ovf` output 1, signed overflow: the borrow into the MSB XOR `b_out`.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
- IDLE & `start`=1:
  - Latch `a` and `b` into internal shift registers `sa` and `sb`, and `b_in` into borrow register `br`.
  - Clear the bit counter `cnt` to 0 and clear the internal result shift register.
  - Go to RUN.
- RUN, each cycle:
  - Take bit `x=sa[0]`, `y=sb[0]`.
  - Difference bit `x^y^br`.
  - Next borrow `(~x&y) | (~(x^y)&br)`.
  - Shift the difference bit into the MSB of the internal result register.
  - Shift `sa` and `sb` right by one, update `br`, then `cnt`+1.
  - When `cnt == WIDTH-2` is processed, save the current `br` as the borrow into the MSB for `ovf`.
- RUN & `cnt == WIDTH-1` (last bit):
  - Write the completed result to `d`.
  - Write the final borrow to `b_out`.
  - Compute `zero`, `neg` and `ovf` from the completed result.
  - Pulse `done`=1 and return to IDLE.
- `d`, `b_out`, `zero`, `neg` and `ovf` change only on completion. They hold their last value through IDLE and the whole of the next RUN, and partial results are never visible.
- `start` while `busy`=1 is ignored: no latch, no effect on the current operation.
- `a`, `b` and `b_in` are don't-care except in the cycle where `start` is accepted.
- `b_in=1` with `a == b` gives `d`=all-ones and `b_out`=1.

## Timing
- Reset (async assert, any state, including mid-RUN):
  - State goes to IDLE and the current operation is aborted with no `done`.
  - `busy`=0, `done`=0, `d`=0, `b_out`=0, `zero`=0, `neg`=0, `ovf`=0.
  - `cnt`, `br` and the shift registers clear to 0.
- Deassertion of reset takes effect on the next rising edge.
- Latency, with `start` accepted at edge E0:
  - `busy`=1 from E0 to E`WIDTH`.
  - Bits 0..WIDTH-1 are processed at edges E1..E`WIDTH`.
  - At E`WIDTH` the outputs update, `done` rises and `busy` falls. `done` is high for exactly one cycle, cleared at E`WIDTH+1`.
- Back-to-back: `start` may be high in the same cycle `done` is high (state is IDLE) and is accepted at E`WIDTH+1`. Throughput is one operation per WIDTH+1 cycles (17 cycles at default).
- `start` held high continuously launches a new operation every WIDTH+1 cycles.
- There is no combinational path from any input to any output.

## Test plan
- a=0x0005, b=0x0003, b_in=0, start 1 cycle -> after 16 cycles `done` pulses once: d=0x0002, b_out=0, zero=0, neg=0, ovf=0; `busy` high for exactly 16 cycles.
- a=0x0000, b=0x0001, b_in=0 -> d=0xFFFF, b_out=1, neg=1, ovf=0.
- a=0x8000, b=0x0001, b_in=0 -> d=0x7FFF, b_out=0, neg=0, ovf=1.
- a=0x1234, b=0x1233, b_in=1 -> d=0x0000, zero=1, b_out=0, ovf=0. Then a=0x1234, b=0x1234, b_in=1 -> d=0xFFFF, b_out=1.
- Start a=0x00FF, b=0x000F. At cycle 5 pulse `start` with a=0xFFFF, b=0 -> ignored, result d=0x00F0. Re-run with `rst_n` asserted at cycle 8 -> all outputs 0 immediately, no `done`, then the next `start` works normally.
- 200 random triples with `start` held high continuously -> `done` every 17 cycles; each result matches `{b_out,d} = {1'b0,a} - b - b_in` and the flag definitions; outputs are stable between `done` pulses.
